// File: rtl/add8_arb_pkg.sv
// Shared constants and round-robin helper for add8_share_arb.
// Picker supports up to 8 requesters.
package add8_arb_pkg;
   localparam int ADD_W    = 8;
   localparam int SUM_W    = 9;
   localparam int ERRCNT_W = 16;
   localparam int MAXREQ   = 8;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } rr_t;

   // Lowest offset from ptr+1 wins, so scan offsets high to low.
   function automatic rr_t rr_next(
      input logic [2:0]        ptr,
      input logic [MAXREQ-1:0] valid,
      input int                n
   );
      rr_t r;
      int  j;
      r = '0;
      for (int k = MAXREQ; k >= 1; k--) begin
         if (k <= n) begin
            j = (int'(ptr) + k) % n;
            if (valid[j]) begin
               r.hit = 1'b1;
               r.idx = 3'(j);
            end
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/add8_share_arb_if.sv
// Requester, adder and response signals of add8_share_arb.
// slave: the arbiter side; master: producers/adder/consumer side.
interface add8_share_arb_if
   import add8_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int TAG_W = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*ADD_W-1:0] req_a;
   logic [NREQ*ADD_W-1:0] req_b;
   logic [NREQ*TAG_W-1:0] req_tag;
   logic [ADD_W-1:0]      add_a;
   logic [ADD_W-1:0]      add_b;
   logic [SUM_W-1:0]      add_o;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [SUM_W-1:0]      rsp_sum;
   logic [IDW-1:0]        rsp_id;
   logic [TAG_W-1:0]      rsp_tag;
   logic [SUM_W-1:0]      rsp_err;
   logic [ERRCNT_W-1:0]   err_cnt;

   modport slave (
      input  req_valid, req_a, req_b, req_tag,
      input  add_o, rsp_ready,
      output req_ready, add_a, add_b,
      output rsp_valid, rsp_sum, rsp_id,
      output rsp_tag, rsp_err, err_cnt
   );

   modport master (
      output req_valid, req_a, req_b, req_tag,
      output add_o, rsp_ready,
      input  req_ready, add_a, add_b,
      input  rsp_valid, rsp_sum, rsp_id,
      input  rsp_tag, rsp_err, err_cnt
   );
endinterface

// File: rtl/add8_rr_pick.sv
// Combinational round-robin picker: first valid above ptr,
// wrapping modulo NREQ.
module add8_rr_pick
   import add8_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_any
);
   logic [MAXREQ-1:0] v8;
   rr_t               r;

   always_comb begin
      v8            = '0;
      v8[NREQ-1:0]  = valid;
      r             = rr_next(3'(ptr), v8, NREQ);
      gnt_any       = r.hit;
      gnt_idx       = IDW'(r.idx);
   end
endmodule

// File: rtl/add8_share_arb.sv
// Shares one external 8-bit adder among NREQ requesters, 2-stage.
// Define ADD8_ERR_MON_EN to add the exact-sum error monitor.
module add8_share_arb
   import add8_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int TAG_W = 4
) (
   input logic             clk,
   input logic             rst_n,
   add8_share_arb_if.slave bus
);
   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic             s1_valid_q;
   logic [ADD_W-1:0] s1_a_q, s1_b_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic [IDW-1:0]   s1_id_q;
   logic             rsp_valid_q;
   logic [SUM_W-1:0] rsp_sum_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [TAG_W-1:0] rsp_tag_q;
   logic             s2_adv, s1_adv, acc, cap;
   logic [ADD_W-1:0] gnt_a, gnt_b;
   logic [TAG_W-1:0] gnt_tag;
   logic [NREQ-1:0]  rdy;

   add8_rr_pick #(.NREQ(NREQ)) u_pick (
      .valid   (bus.req_valid),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // rst_n gate keeps req_ready low while reset is held.
   always_comb begin
      s2_adv  = !rsp_valid_q | bus.rsp_ready;
      s1_adv  = !s1_valid_q | s2_adv;
      acc     = s1_adv & gnt_any & rst_n;
      cap     = s1_valid_q & s2_adv;
      gnt_a   = bus.req_a[int'(gnt_idx)*ADD_W +: ADD_W];
      gnt_b   = bus.req_b[int'(gnt_idx)*ADD_W +: ADD_W];
      gnt_tag = bus.req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
      rdy     = '0;
      if (acc) rdy[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= IDW'(NREQ - 1);
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_tag_q    <= '0;
         s1_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
         rsp_tag_q   <= '0;
      end else begin
         if (acc) begin
            ptr_q    <= gnt_idx;
            s1_a_q   <= gnt_a;
            s1_b_q   <= gnt_b;
            s1_tag_q <= gnt_tag;
            s1_id_q  <= gnt_idx;
         end
         if (s1_adv) s1_valid_q <= acc;
         if (s2_adv) rsp_valid_q <= s1_valid_q;
         if (cap) begin
            rsp_sum_q <= bus.add_o;
            rsp_id_q  <= s1_id_q;
            rsp_tag_q <= s1_tag_q;
         end
      end
   end

   assign bus.req_ready = rdy;
   assign bus.add_a     = s1_a_q;
   assign bus.add_b     = s1_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_tag   = rsp_tag_q;

`ifdef ADD8_ERR_MON_EN
   logic [SUM_W-1:0]    exact_q, err_d, err_q;
   logic [ERRCNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      if (exact_q >= bus.add_o) err_d = exact_q - bus.add_o;
      else                      err_d = bus.add_o - exact_q;
      cnt_d = cnt_q;
      if (err_d != '0 && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exact_q <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (acc) exact_q <= {1'b0, gnt_a} + {1'b0, gnt_b};
         if (cap) begin
            err_q <= err_d;
            cnt_q <= cnt_d;
         end
      end
   end

   assign bus.rsp_err = err_q;
   assign bus.err_cnt = cnt_q;
`else
   assign bus.rsp_err = '0;
   assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_add8_share_arb.sv
// Directed bench for add8_share_arb with a mock adder that can
// be biased by -8 to exercise the error monitor.
module tb_add8_share_arb;
   import add8_arb_pkg::*;

   logic clk;
   logic rst_n;
   logic bias;
   int   n_chk;
   int   n_bad;

   add8_share_arb_if #(.NREQ(4), .TAG_W(4)) bus ();

   add8_share_arb #(.NREQ(4), .TAG_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign bus.add_o = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                    - (bias ? 9'd8 : 9'd0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [3:0] t);
      bus.req_a[8*i +: 8]   = a;
      bus.req_b[8*i +: 8]   = b;
      bus.req_tag[4*i +: 4] = t;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      cyc();
   endtask

`ifdef ADD8_ERR_MON_EN
   localparam int EXP_ERR = 8;
   localparam int EXP_CNT = 1;
`else
   localparam int EXP_ERR = 0;
   localparam int EXP_CNT = 0;
`endif

   initial begin
      n_chk         = 0;
      n_bad         = 0;
      bias          = 1'b0;
      rst_n         = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b1;
      #12;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_add_a", 32'(bus.add_a), 0);
      chk("rst_add_b", 32'(bus.add_b), 0);
      chk("rst_sum", 32'(bus.rsp_sum), 0);
      chk("rst_id", 32'(bus.rsp_id), 0);
      chk("rst_tag", 32'(bus.rsp_tag), 0);
      chk("rst_err", 32'(bus.rsp_err), 0);
      chk("rst_cnt", 32'(bus.err_cnt), 0);
      bus.req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // single request from requester 2
      set_req(2, 8'h7F, 8'h01, 4'd5);
      bus.req_valid = 4'b0100;
      #1;
      chk("t1_ready", 32'(bus.req_ready), 4'b0100);
      cyc();
      bus.req_valid = '0;
      #1;
      chk("t1_s1_noval", 32'(bus.rsp_valid), 0);
      chk("t1_add_a", 32'(bus.add_a), 8'h7F);
      chk("t1_add_b", 32'(bus.add_b), 8'h01);
      cyc();
      chk("t1_valid", 32'(bus.rsp_valid), 1);
      chk("t1_sum", 32'(bus.rsp_sum), 9'h080);
      chk("t1_id", 32'(bus.rsp_id), 2);
      chk("t1_tag", 32'(bus.rsp_tag), 5);
      cyc();
      chk("t1_done", 32'(bus.rsp_valid), 0);

      // all four valid from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++)
         set_req(i, 8'(8'h10 * i + 1), 8'(i), 4'(i + 8));
      for (int c = 0; c < 9; c++) begin
         bus.req_valid = (c < 6) ? 4'b1111 : 4'b0000;
         #1;
         chk($sformatf("rr_ready%0d", c), 32'(bus.req_ready),
             (c < 6) ? (32'd1 << (c % 4)) : 0);
         if (c >= 2 && c < 8) begin
            chk($sformatf("rr_val%0d", c), 32'(bus.rsp_valid), 1);
            chk($sformatf("rr_id%0d", c), 32'(bus.rsp_id),
                (c - 2) % 4);
            chk($sformatf("rr_sum%0d", c), 32'(bus.rsp_sum),
                8'h11 * ((c - 2) % 4) + 1);
            chk($sformatf("rr_tag%0d", c), 32'(bus.rsp_tag),
                (c - 2) % 4 + 8);
         end else begin
            chk($sformatf("rr_nov%0d", c), 32'(bus.rsp_valid), 0);
         end
         cyc();
      end

      // back-pressure: ptr is 1, so grants 2 then 3
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      #1;
      chk("bp_g2", 32'(bus.req_ready), 4'b0100);
      cyc();
      chk("bp_g3", 32'(bus.req_ready), 4'b1000);
      cyc();
      for (int c = 0; c < 5; c++) begin
         chk("bp_ready0", 32'(bus.req_ready), 0);
         chk("bp_valid", 32'(bus.rsp_valid), 1);
         chk("bp_id", 32'(bus.rsp_id), 2);
         chk("bp_sum", 32'(bus.rsp_sum), 9'h023);
         chk("bp_s1_a", 32'(bus.add_a), 8'h31);
         cyc();
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      #1;
      chk("bp_rel_id", 32'(bus.rsp_id), 2);
      cyc();
      chk("bp_dr_val", 32'(bus.rsp_valid), 1);
      chk("bp_dr_id", 32'(bus.rsp_id), 3);
      chk("bp_dr_sum", 32'(bus.rsp_sum), 9'h034);
      cyc();
      chk("bp_empty", 32'(bus.rsp_valid), 0);

      // error monitor with a biased adder
      bias = 1'b1;
      set_req(0, 8'hFF, 8'hFF, 4'd1);
      bus.req_valid = 4'b0001;
      #1;
      chk("em_ready", 32'(bus.req_ready), 4'b0001);
      cyc();
      bus.req_valid = '0;
      cyc();
      chk("em_sum", 32'(bus.rsp_sum), 9'h1F6);
      chk("em_err", 32'(bus.rsp_err), EXP_ERR);
      chk("em_cnt", 32'(bus.err_cnt), EXP_CNT);
      bias = 1'b0;
      set_req(0, 8'h10, 8'h00, 4'd2);
      bus.req_valid = 4'b0001;
      cyc();
      bus.req_valid = '0;
      cyc();
      chk("ex_sum", 32'(bus.rsp_sum), 9'h010);
      chk("ex_tag", 32'(bus.rsp_tag), 2);
      chk("ex_err", 32'(bus.rsp_err), 0);
      chk("ex_cnt", 32'(bus.err_cnt), EXP_CNT);

      // reset while S1 and S2 are full
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b1111;
      cyc();
      cyc();
      chk("mr_full", 32'(bus.rsp_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.rsp_valid), 0);
      chk("mr_ready", 32'(bus.req_ready), 0);
      chk("mr_add_a", 32'(bus.add_a), 0);
      chk("mr_sum", 32'(bus.rsp_sum), 0);
      chk("mr_id", 32'(bus.rsp_id), 0);
      chk("mr_cnt", 32'(bus.err_cnt), 0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("mr_first", 32'(bus.req_ready), 4'b0001);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk("mr_norsp", 32'(bus.rsp_valid), 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
